// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker: FSM state
// encoding, default expected words and the slave word addresses.
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    COMPARE
  } state_t;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd1;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1392680969;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_checker_cnt.sv
// Loadable saturating up-counter with synchronous clear and a
// terminal-count flag. Stops at MAX instead of wrapping.
module sysid_checker_cnt #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255,
  parameter int TC    = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] TC_V  = WIDTH'(TC);

  logic [WIDTH-1:0] count;

  // Count register: clear wins over load, load wins over increment.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc && (count != MAX_V)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == TC_V);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (ID word, then
// timestamp word), compares both against build-time constants and
// reports pass / timeout with a one-cycle done pulse.
// Optional periodic re-check: define SYSID_CHECKER_PERIODIC_EN.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          READ_LATENCY   = 1,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          PERIOD_CYCLES  = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam int LAT_W   = $clog2(READ_LATENCY + 1);
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end
  if (PERIOD_CYCLES < 1) begin : g_bad_period
    $error("PERIOD_CYCLES must be at least 1");
  end

  state_t state, state_next;
  logic   start_any;
  logic   done_set;
  logic   rd_accept;
  logic   abort;
  logic   lat_tc;
  logic   stall_tc;
  logic   in_wait;

  assign rd_accept = avm_read && !avm_waitrequest;
  assign abort     = avm_read && avm_waitrequest && stall_tc;
  assign in_wait   = (state == WAIT_ID) || (state == WAIT_TS);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and Avalon strobes.
  // NOTE: every output gets a default before the case so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    avm_read    = 1'b0;
    avm_address = ADDR_ID;
    done_set    = 1'b0;
    case (state)
      IDLE: begin
        if (start_any) state_next = RD_ID;
      end
      RD_ID: begin
        busy     = 1'b1;
        avm_read = 1'b1;
        if (avm_waitrequest && stall_tc) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end else if (!avm_waitrequest) begin
          state_next = WAIT_ID;
        end
      end
      WAIT_ID: begin
        busy = 1'b1;
        if (lat_tc) state_next = RD_TS;
      end
      RD_TS: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = ADDR_TS;
        if (avm_waitrequest && stall_tc) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end else if (!avm_waitrequest) begin
          state_next = WAIT_TS;
        end
      end
      WAIT_TS: begin
        busy = 1'b1;
        if (lat_tc) begin
          state_next = COMPARE;
          done_set   = 1'b1;
        end
      end
      COMPARE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result flags and captured words.
  always_ff @(posedge clock) begin
    if (reset) begin
      done     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      done <= done_set;
      case (state)
        IDLE: begin
          if (start_any) begin
            pass     <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
          end
        end
        RD_ID, RD_TS: begin
          if (abort) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        WAIT_ID: if (lat_tc) id_value <= avm_readdata;
        WAIT_TS: if (lat_tc) ts_value <= avm_readdata;
        COMPARE: pass <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
        default: ;
      endcase
    end
  end

  // Read-latency counter: loaded with 1 on the accept edge, so it equals
  // READ_LATENCY in the wait cycle where the slave data is valid.
  sysid_checker_cnt #(
    .WIDTH (LAT_W),
    .MAX   (READ_LATENCY),
    .TC    (READ_LATENCY)
  ) u_lat_cnt (
    .clock      (clock),
    .reset      (reset),
    .clear      (state == IDLE),
    .load       (rd_accept),
    .load_value (LAT_W'(1)),
    .inc        (in_wait),
    .tc         (lat_tc)
  );

  // Stall counter: held at zero outside the read states, so each read
  // starts fresh; flags the cycle that would be the final allowed stall.
  sysid_checker_cnt #(
    .WIDTH (STALL_W),
    .MAX   (TIMEOUT_CYCLES),
    .TC    (TIMEOUT_CYCLES - 1)
  ) u_stall_cnt (
    .clock      (clock),
    .reset      (reset),
    .clear      (!avm_read),
    .load       (1'b0),
    .load_value ('0),
    .inc        (avm_read && avm_waitrequest),
    .tc         (stall_tc)
  );

`ifdef SYSID_CHECKER_PERIODIC_EN
  localparam int PERIOD_W = $clog2(PERIOD_CYCLES + 1);

  logic armed;
  logic period_tc;

  // Periodic checking arms after the first completed check.
  always_ff @(posedge clock) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (done) begin
      armed <= 1'b1;
    end
  end

  // Interval counter counts IDLE cycles after each done; leaving IDLE
  // (including via an external start) restarts the interval.
  sysid_checker_cnt #(
    .WIDTH (PERIOD_W),
    .MAX   (PERIOD_CYCLES),
    .TC    (PERIOD_CYCLES - 1)
  ) u_period_cnt (
    .clock      (clock),
    .reset      (reset),
    .clear      ((state != IDLE) || done),
    .load       (1'b0),
    .load_value ('0),
    .inc        (armed),
    .tc         (period_tc)
  );

  assign start_any = start || ((state == IDLE) && armed && period_tc);
`else
  assign start_any = start;
`endif

endmodule

// File: tb/tb_sysid_checker.sv
// Self-checking bench for sysid_checker: a behavioural Avalon slave with
// programmable stalls, and expected timing/results derived from the
// read-sequence arithmetic (accept cycles, latency, stall budget).
module tb_sysid_checker;

  localparam int          LAT     = 1;
  localparam int          TMO     = 255;
  localparam int          PER     = 100;
  localparam logic [31:0] EXP_ID  = 32'd1;
  localparam logic [31:0] EXP_TS  = 32'd1392680969;

  logic        clock;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  sysid_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .READ_LATENCY   (LAT),
    .TIMEOUT_CYCLES (TMO),
    .PERIOD_CYCLES  (PER)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Slave model state.
  logic [31:0] mem [2];
  int          stall_left [2];
  logic [31:0] sched [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of cycle c: answers the current read request
  // and presents whatever data is due in this cycle.
  task automatic slave_cycle(input int c);
    if (avm_read) begin
      if (stall_left[avm_address] > 0) begin
        avm_waitrequest = 1'b1;
        stall_left[avm_address]--;
      end else begin
        avm_waitrequest = 1'b0;
        sched[c + LAT] = mem[avm_address];
      end
    end else begin
      avm_waitrequest = 1'($urandom_range(0, 1));
    end
    avm_readdata = sched.exists(c) ? sched[c] : $urandom();
  endtask

  task automatic run_check(input logic [31:0] id_w, input logic [31:0] ts_w,
                           input int s_id, input int s_ts, input bit poke, input string tag);
    int exp_done, first_done, done_cnt, busy_bad, addr_bad, rd0, rd1, exp_rd0, exp_rd1;
    bit exp_to, exp_pass;
    logic [31:0] exp_id, exp_ts;
    logic [31:0] got_pass, got_to, got_id, got_ts;
    if (s_id >= TMO) begin
      exp_done = 1 + TMO; exp_to = 1; exp_id = '0; exp_ts = '0;
      exp_rd0 = TMO; exp_rd1 = 0;
    end else if (s_ts >= TMO) begin
      exp_done = 2 + s_id + LAT + TMO; exp_to = 1; exp_id = id_w; exp_ts = '0;
      exp_rd0 = s_id + 1; exp_rd1 = TMO;
    end else begin
      exp_done = 3 + 2 * LAT + s_id + s_ts; exp_to = 0; exp_id = id_w; exp_ts = ts_w;
      exp_rd0 = s_id + 1; exp_rd1 = s_ts + 1;
    end
    exp_pass = !exp_to && (id_w == EXP_ID) && (ts_w == EXP_TS);
    mem[0] = id_w; mem[1] = ts_w;
    stall_left[0] = s_id; stall_left[1] = s_ts;
    sched.delete();
    first_done = -1; done_cnt = 0; busy_bad = 0; addr_bad = 0; rd0 = 0; rd1 = 0;
    got_pass = 'x; got_to = 'x; got_id = 'x; got_ts = 'x;
    @(negedge clock);
    start = 1'b1;
    slave_cycle(0);
    for (int c = 1; c <= exp_done + 3; c++) begin
      @(negedge clock);
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
      end
      if (busy !== (c < exp_done)) busy_bad++;
      if (avm_read && avm_address == 1'b0) rd0++;
      if (avm_read && avm_address == 1'b1) rd1++;
      if (!avm_read && avm_address !== 1'b0) addr_bad++;
      if (c == exp_done + 1) begin
        got_pass = 32'(pass); got_to = 32'(timeout); got_id = id_value; got_ts = ts_value;
      end
      start = (poke && c == 2 + s_id) ? 1'b1 : 1'b0;
      slave_cycle(c);
    end
    check({tag, ".done_cycle"}, 32'(first_done), 32'(exp_done));
    check({tag, ".done_count"}, 32'(done_cnt), 32'd1);
    check({tag, ".busy"}, 32'(busy_bad), 32'd0);
    check({tag, ".addr_idle"}, 32'(addr_bad), 32'd0);
    check({tag, ".rd_id_cycles"}, 32'(rd0), 32'(exp_rd0));
    check({tag, ".rd_ts_cycles"}, 32'(rd1), 32'(exp_rd1));
    check({tag, ".pass"}, got_pass, 32'(exp_pass));
    check({tag, ".timeout"}, got_to, 32'(exp_to));
    check({tag, ".id_value"}, got_id, exp_id);
    check({tag, ".ts_value"}, got_ts, exp_ts);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones [$];
    logic [31:0] rid, rts;
    reset = 1'b1; start = 1'b0; avm_waitrequest = 1'b0; avm_readdata = '0;
    mem[0] = EXP_ID; mem[1] = EXP_TS; stall_left[0] = 0; stall_left[1] = 0;
    repeat (3) @(negedge clock);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.pass", 32'(pass), 32'd0);
    check("rst.timeout", 32'(timeout), 32'd0);
    check("rst.id_value", id_value, 32'd0);
    check("rst.ts_value", ts_value, 32'd0);
    check("rst.read", 32'(avm_read), 32'd0);
    check("rst.address", 32'(avm_address), 32'd0);
    reset = 1'b0;

    run_check(EXP_ID, EXP_TS, 0, 0, 0, "nominal");
    run_check(EXP_ID, 32'h12345678, 0, 0, 0, "ts_mismatch");
    run_check(EXP_ID, EXP_TS, 3, 0, 0, "stall_id");
    run_check(EXP_ID, EXP_TS, 1000, 0, 0, "timeout_id");
    run_check(EXP_ID, EXP_TS, 2, 1, 0, "recover");
    run_check(EXP_ID, EXP_TS, 0, 300, 0, "timeout_ts");
    run_check(EXP_ID, EXP_TS, 1, 2, 1, "start_ignored");

    // Reset asserted while waiting for the timestamp data.
    mem[0] = EXP_ID; mem[1] = EXP_TS; stall_left[0] = 0; stall_left[1] = 0;
    sched.delete();
    @(negedge clock);
    start = 1'b1;
    slave_cycle(0);
    for (int c = 1; c <= 3 + LAT; c++) begin
      @(negedge clock);
      start = 1'b0;
      slave_cycle(c);
    end
    check("mid.id_captured", id_value, EXP_ID);
    reset = 1'b1;
    @(negedge clock);
    check("mid.busy", 32'(busy), 32'd0);
    check("mid.done", 32'(done), 32'd0);
    check("mid.read", 32'(avm_read), 32'd0);
    check("mid.id_value", id_value, 32'd0);
    check("mid.ts_value", ts_value, 32'd0);
    check("mid.pass", 32'(pass), 32'd0);
    reset = 1'b0;
    sched.delete();
    run_check(EXP_ID, EXP_TS, 0, 0, 0, "after_reset");

    // Randomized checks: words sometimes wrong, random stalls.
    for (int i = 0; i < 8; i++) begin
      rid = ($urandom_range(0, 2) == 0) ? $urandom() : EXP_ID;
      rts = ($urandom_range(0, 2) == 0) ? $urandom() : EXP_TS;
      run_check(rid, rts, $urandom_range(0, 4), $urandom_range(0, 4), 0, $sformatf("rand%0d", i));
    end

    // start held high restarts on the return to IDLE.
    mem[0] = EXP_ID; mem[1] = EXP_TS; stall_left[0] = 0; stall_left[1] = 0;
    sched.delete();
    dones.delete();
    @(negedge clock);
    start = 1'b1;
    slave_cycle(0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clock);
      if (done) dones.push_back(c);
      start = (c <= 3 + 2 * LAT + 1) ? 1'b1 : 1'b0;
      slave_cycle(c);
    end
    check("held.done_count", 32'(dones.size()), 32'd2);
    if (dones.size() == 2) begin
      check("held.first", 32'(dones[0]), 32'(3 + 2 * LAT));
      check("held.second", 32'(dones[1]), 32'(2 * (3 + 2 * LAT) + 1));
    end

`ifdef SYSID_CHECKER_PERIODIC_EN
    // One external start, then the interval counter issues the next one.
    dones.delete();
    sched.delete();
    @(negedge clock);
    start = 1'b1;
    slave_cycle(0);
    for (int c = 1; c <= 3 + 2 * LAT + PER + 3 + 2 * LAT + 2; c++) begin
      @(negedge clock);
      if (done) dones.push_back(c);
      start = 1'b0;
      slave_cycle(c);
    end
    check("periodic.done_count", 32'(dones.size()), 32'd2);
    if (dones.size() == 2) begin
      check("periodic.first", 32'(dones[0]), 32'(3 + 2 * LAT));
      check("periodic.second", 32'(dones[1]), 32'(2 * (3 + 2 * LAT) + PER));
    end
`else
    // Without the periodic feature no check happens spontaneously.
    dones.delete();
    for (int c = 0; c < 2 * PER; c++) begin
      @(negedge clock);
      if (done) dones.push_back(c);
      slave_cycle(c);
    end
    check("no_auto.done_count", 32'(dones.size()), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM master placed directly downstream of the system-ID slave. On request, it reads the ID word (address 0) and then the timestamp word (address 1).
- Compares both words against build-time expected values and reports pass, fail or timeout to boot/health logic.
- Keeps the captured words available for debug readout.

Parameters:
- EXPECTED_ID, 32'd1, expected word at address 0.
- EXPECTED_TS, 32'd1392680969, expected word at address 1.
- READ_LATENCY, 1, fixed slave read latency in cycles (legal 1..4).
- TIMEOUT_CYCLES, 255, maximum waitrequest stall per read before abort (legal 1..65535).
- PERIOD_CYCLES, 1000000, auto-recheck interval; used only with the optional feature.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a check; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at the end of a check
- pass  out  1  sticky result: both words matched
- timeout  out  1  sticky: a read stalled for TIMEOUT_CYCLES
- id_value  out  32  word captured from address 0
- ts_value  out  32  word captured from address 1
- avm_address  out  1  slave word address
- avm_read  out  1  read strobe
- avm_readdata  in  32  slave read data
- avm_waitrequest  in  1  slave stall

Behaviour:
- Reset values: every output is 0; FSM is in IDLE; all counters are 0.
- FSM states: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, COMPARE.
- IDLE: start=1 clears pass, timeout, id_value and ts_value, then moves to RD_ID.
- RD_ID: drive avm_read=1 and avm_address=0. Hold both stable while avm_waitrequest=1. The read is accepted on the first cycle with waitrequest=0, then go to WAIT_ID.
- WAIT_ID: count READ_LATENCY cycles. Data is valid READ_LATENCY cycles after the accept cycle; capture it into id_value on that edge, then go to RD_TS.
- RD_TS and WAIT_TS: same as RD_ID and WAIT_ID, using avm_address=1 and ts_value.
- COMPARE: pass <= (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TS); done pulses; return to IDLE.
- Latency: start sampled in cycle 0 with waitrequest held low gives done=1 in cycle 3+2*READ_LATENCY (5 for READ_LATENCY=1).
- avm_read is high only in RD_ID and RD_TS. avm_address is 0 outside RD_TS.
- Stall counter: reset on entry to each RD state and incremented each cycle with read=1 and waitrequest=1.
  - Reaching TIMEOUT_CYCLES sets timeout=1 and pass=0, pulses done and returns to IDLE.
  - read deasserts in the cycle after the abort.
  - A TS-read timeout keeps the already captured id_value.
- start while busy or in COMPARE is ignored; start is not queued.
- start held high continuously restarts a check on each return to IDLE.
- Counters saturate, never wrap. Stall counter width is clog2(TIMEOUT_CYCLES+1).
- reset asserted mid-operation: on the next edge all outputs return to 0, read drops, and the in-flight read data is discarded.

Optional Feature:
- Macro: SYSID_CHECKER_PERIODIC_EN.
- Defined:
  - An interval counter starts after each done and auto-issues an internal start after PERIOD_CYCLES cycles in IDLE.
  - External start remains functional and resets the interval counter.
  - A periodic failure leaves pass=0 until the next passing check.
- Undefined: checks run only on external start; PERIOD_CYCLES is unused and no interval counter is synthesized.

Decomposition:
- Package sysid_checker_pkg:
  - FSM state enum;
  - default EXPECTED_ID and EXPECTED_TS constants;
  - address constants ADDR_ID=0 and ADDR_TS=1.
- One sub-module, sysid_checker_cnt: a loadable saturating counter with clear, increment and terminal-count flag.
  - Three instances: latency counter, stall counter, and period counter (the period instance exists only when the macro is defined).

Test Plan:
- Nominal pass: slave returns 1 and 1392680969, waitrequest=0, READ_LATENCY=1, start in cycle 0 -> done in cycle 5, pass=1, id_value=1, ts_value=1392680969, busy high cycles 1-4.
- Timestamp mismatch: slave returns 0x12345678 at address 1 -> done, pass=0, timeout=0, ts_value=0x12345678.
- Stall tolerance: waitrequest high for 3 cycles during the ID read -> read held with address 0 for 4 cycles, done 3 cycles later than nominal, pass=1.
- Timeout: waitrequest stuck high, TIMEOUT_CYCLES=255 -> timeout=1, pass=0 and done pulse after 255 stall cycles; read low the next cycle.
- Start ignored and reset mid-operation:
  - start pulsed while in WAIT_ID -> exactly one done;
  - reset asserted in WAIT_TS -> all outputs 0 and state IDLE next cycle;
  - a following start -> a complete pass.
- Periodic (macro defined, PERIOD_CYCLES=100): one external start -> second done occurs exactly 100 IDLE cycles after the first, with no further start.
